// File: rtl/monitor_pkg.sv
// Shared opcodes, header layout and state encoding for the serial monitor sequencer.
package monitor_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_DUMP = 8'h02;

  localparam int unsigned HDR_LEN    = 5;
  localparam int unsigned ADDR_BYTES = 3;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_HDR       = 4'd1,
    ST_LOAD      = 4'd2,
    ST_DUMP_RD   = 4'd3,
    ST_DUMP_WAIT = 4'd4,
    ST_DUMP_TX   = 4'd5,
    ST_DUMP_GAP  = 4'd6,
    ST_ACK       = 4'd7,
    ST_NAK       = 4'd8,
    ST_GAP       = 4'd9
  } state_t;

endpackage

// File: rtl/monitor_ctrl_tx_sender.sv
// UART transmit handshake: wait for idle, register a one-cycle start pulse, then hold off
// for the transmitter's busy flag to rise.
module tx_sender (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] data,
  input  logic       is_transmitting,
  output logic       fire,
  output logic [7:0] tx_byte,
  output logic       transmit
);

  logic guard;

  // Blocked during the pulse cycle and the one after it, while the busy flag catches up.
  assign fire = req && !is_transmitting && !transmit && !guard;

  always_ff @(posedge clk) begin
    if (rst) begin
      transmit <= 1'b0;
      guard    <= 1'b0;
      tx_byte  <= '0;
    end else begin
      transmit <= fire;
      guard    <= transmit;
      if (fire) tx_byte <= data;
    end
  end

endmodule

// File: rtl/monitor_ctrl.sv
// Serial monitor command sequencer: parses load/dump frames from the receive FIFO and
// drives the block-RAM ports and the UART transmit handshake.
module monitor_ctrl
  import monitor_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter logic [7:0]  ACK_BYTE   = 8'h06,
  parameter logic [7:0]  NAK_BYTE   = 8'h15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [7:0]            fifo_data,
  output logic                  fifo_read,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [7:0]            mem_din,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [7:0]            mem_dout,
  output logic [7:0]            tx_byte,
  output logic                  transmit,
  input  logic                  is_transmitting,
  output logic                  busy,
  output logic                  cmd_err
);

  state_t                state, state_n;
  logic [2:0]            hdr_cnt, hdr_cnt_n;
  logic [7:0]            cmd, cmd_n;
  logic [ADDR_WIDTH-1:0] ptr, ptr_n;
  logic [15:0]           len, len_n;
  logic [15:0]           cnt, cnt_n;
  logic [7:0]            dbyte, dbyte_n;
  logic [ADDR_WIDTH-1:0] raddr_n, waddr_n;
  logic [7:0]            din_n;
  logic                  fifo_read_n, mem_we_n, cmd_err_n;
  logic                  can_pop;
  logic                  tx_req, tx_fire;
  logic [7:0]            tx_data;

  // The FIFO head is stale during the cycle its pop pulse is visible.
  assign can_pop = !fifo_empty && !fifo_read;
  assign busy    = (state != ST_IDLE);

  assign tx_req  = (state == ST_DUMP_TX) || (state == ST_ACK) || (state == ST_NAK);
  assign tx_data = (state == ST_ACK) ? ACK_BYTE :
                   (state == ST_NAK) ? NAK_BYTE : dbyte;

  tx_sender u_tx_sender (
    .clk             (clk),
    .rst             (rst),
    .req             (tx_req),
    .data            (tx_data),
    .is_transmitting (is_transmitting),
    .fire            (tx_fire),
    .tx_byte         (tx_byte),
    .transmit        (transmit)
  );

  always_comb begin
    state_n     = state;
    hdr_cnt_n   = hdr_cnt;
    cmd_n       = cmd;
    ptr_n       = ptr;
    len_n       = len;
    cnt_n       = cnt;
    dbyte_n     = dbyte;
    raddr_n     = mem_raddr;
    waddr_n     = mem_waddr;
    din_n       = mem_din;
    fifo_read_n = 1'b0;
    mem_we_n    = 1'b0;
    cmd_err_n   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (can_pop) begin
          cmd_n       = fifo_data;
          fifo_read_n = 1'b1;
          hdr_cnt_n   = '0;
          state_n     = ST_HDR;
        end
      end
      ST_HDR: begin
        if (can_pop) begin
          fifo_read_n = 1'b1;
          hdr_cnt_n   = hdr_cnt + 3'd1;
          // Shifting keeps only the low ADDR_WIDTH bits of the 24-bit address.
          if (hdr_cnt < 3'(ADDR_BYTES)) ptr_n = {ptr[ADDR_WIDTH-9:0], fifo_data};
          else                          len_n = {len[7:0], fifo_data};
          if (hdr_cnt == 3'(HDR_LEN - 1)) begin
            cnt_n = '0;
            case (cmd)
              CMD_LOAD: state_n = (len_n == 16'd0) ? ST_ACK : ST_LOAD;
              CMD_DUMP: begin
                raddr_n = ptr;
                state_n = (len_n == 16'd0) ? ST_IDLE : ST_DUMP_RD;
              end
              default: begin
                cmd_err_n = 1'b1;
                state_n   = ST_NAK;
              end
            endcase
          end
        end
      end
      ST_LOAD: begin
        if (can_pop) begin
          fifo_read_n = 1'b1;
          mem_we_n    = 1'b1;
          waddr_n     = ptr;
          din_n       = fifo_data;
          ptr_n       = ptr + 1'b1;
          cnt_n       = cnt + 16'd1;
          if (cnt + 16'd1 == len) state_n = ST_ACK;
        end
      end
      ST_DUMP_RD:   state_n = ST_DUMP_WAIT;
      ST_DUMP_WAIT: begin
        dbyte_n = mem_dout;
        state_n = ST_DUMP_TX;
      end
      ST_DUMP_TX:   if (tx_fire) state_n = ST_DUMP_GAP;
      ST_DUMP_GAP: begin
        cnt_n   = cnt + 16'd1;
        raddr_n = mem_raddr + 1'b1;
        state_n = (cnt + 16'd1 == len) ? ST_IDLE : ST_DUMP_RD;
      end
      ST_ACK, ST_NAK: if (tx_fire) state_n = ST_GAP;
      ST_GAP:       state_n = ST_IDLE;
      default:      state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      hdr_cnt   <= '0;
      cmd       <= '0;
      ptr       <= '0;
      len       <= '0;
      cnt       <= '0;
      dbyte     <= '0;
      mem_raddr <= '0;
      mem_waddr <= '0;
      mem_din   <= '0;
      fifo_read <= 1'b0;
      mem_we    <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state     <= state_n;
      hdr_cnt   <= hdr_cnt_n;
      cmd       <= cmd_n;
      ptr       <= ptr_n;
      len       <= len_n;
      cnt       <= cnt_n;
      dbyte     <= dbyte_n;
      mem_raddr <= raddr_n;
      mem_waddr <= waddr_n;
      mem_din   <= din_n;
      fifo_read <= fifo_read_n;
      mem_we    <= mem_we_n;
      cmd_err   <= cmd_err_n;
    end
  end

endmodule

// File: tb/tb_monitor_ctrl.sv
// Bench for monitor_ctrl: FIFO, RAM and UART environment models plus a frame-level
// reference of RAM contents and the expected UART byte stream.
module tb_monitor_ctrl;

  localparam int AW  = 13;
  localparam int MEM = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [7:0]    fifo_data;
  logic          fifo_read;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_din;
  logic [AW-1:0] mem_raddr;
  logic [7:0]    mem_dout;
  logic [7:0]    tx_byte;
  logic          transmit;
  logic          is_transmitting;
  logic          busy;
  logic          cmd_err;
  logic          hold;

  monitor_ctrl #(.ADDR_WIDTH(AW), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read(fifo_read), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_din(mem_din),
    .mem_raddr(mem_raddr), .mem_dout(mem_dout), .tx_byte(tx_byte), .transmit(transmit),
    .is_transmitting(is_transmitting), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Receive FIFO model
  logic [7:0] fq [0:1023];
  int wr = 0;
  int rd = 0;
  assign fifo_empty = (rd == wr);
  assign fifo_data  = fq[rd & 1023];
  always @(posedge clk) if (fifo_read) rd <= rd + 1;

  // Block RAM model, registered read
  logic [7:0] ram [0:MEM-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_din;
    mem_dout <= ram[mem_raddr];
  end

  // UART model: busy rises the cycle after the start pulse
  logic [7:0] tx_log [0:4095];
  int tx_n = 0;
  int busy_cnt = 0;
  assign is_transmitting = (busy_cnt != 0) || hold;
  always @(posedge clk) begin
    if (transmit) begin
      tx_log[tx_n] <= tx_byte;
      tx_n         <= tx_n + 1;
      busy_cnt     <= 12;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Protocol monitor
  int viol = 0;
  int we_cnt = 0;
  int err_cnt = 0;
  logic prev_tx = 1'b0;
  logic prev_rd = 1'b0;
  always @(negedge clk) begin
    if (transmit && is_transmitting) viol <= viol + 1;
    if (transmit && prev_tx)         viol <= viol + 1;
    if (fifo_read && prev_rd)        viol <= viol + 1;
    if (mem_we)  we_cnt  <= we_cnt + 1;
    if (cmd_err) err_cnt <= err_cnt + 1;
    prev_tx <= transmit;
    prev_rd <= fifo_read;
  end

  // Reference model
  logic [7:0] ram_ref [0:MEM-1];
  logic [7:0] exp_tx  [0:4095];
  logic [7:0] pay     [0:255];
  int exp_n = 0;
  int tx_chk = 0;
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fq[wr & 1023] = b;
    wr++;
  endtask

  task automatic hdr(input logic [7:0] c, input logic [23:0] a, input logic [15:0] l);
    push(c); push(a[23:16]); push(a[15:8]); push(a[7:0]); push(l[15:8]); push(l[7:0]);
  endtask

  task automatic do_load(input logic [23:0] a, input int l);
    hdr(8'h01, a, 16'(l));
    for (int i = 0; i < l; i++) begin
      push(pay[i]);
      ram_ref[(int'(a) + i) % MEM] = pay[i];
    end
    exp_tx[exp_n] = 8'h06;
    exp_n++;
  endtask

  task automatic do_dump(input logic [23:0] a, input int l);
    hdr(8'h02, a, 16'(l));
    for (int i = 0; i < l; i++) begin
      exp_tx[exp_n] = ram_ref[(int'(a) + i) % MEM];
      exp_n++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int stable = 0;
    int n = 0;
    while (stable < 4 && n < 20000) begin
      @(negedge clk);
      n++;
      if (fifo_empty && !busy && !is_transmitting) stable++;
      else stable = 0;
    end
    check({tag, "_idle_timeout"}, int'(stable >= 4), 1);
  endtask

  task automatic verify_tx(input string tag);
    int n;
    check({tag, "_tx_count"}, tx_n, exp_n);
    n = (tx_n < exp_n) ? tx_n : exp_n;
    for (int i = tx_chk; i < n; i++) check({tag, "_tx_byte"}, int'(tx_log[i]), int'(exp_tx[i]));
    tx_chk = exp_n;
  endtask

  task automatic check_ram(input string tag, input logic [23:0] a, input int l);
    for (int i = 0; i < l; i++) begin
      int idx;
      idx = (int'(a) + i) % MEM;
      check({tag, "_ram"}, int'(ram[idx]), int'(ram_ref[idx]));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_strobes"}, int'({fifo_read, mem_we, transmit, cmd_err, busy}), 0);
    check({tag, "_tx_byte"}, int'(tx_byte), 0);
    check({tag, "_mem_din"}, int'(mem_din), 0);
    check({tag, "_mem_waddr"}, int'(mem_waddr), 0);
    check({tag, "_mem_raddr"}, int'(mem_raddr), 0);
  endtask

  initial begin
    int base, e0, k, n, n0;
    logic [23:0] a;
    int l, off, dl;

    for (int i = 0; i < MEM; i++) ram_ref[i] = 8'h00;
    rst  = 1'b1;
    hold = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Load then dump
    pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
    do_load(24'h000010, 3);
    wait_idle("load");
    check_ram("load", 24'h000010, 3);
    verify_tx("load");
    base = we_cnt;
    do_dump(24'h000010, 3);
    wait_idle("dump");
    verify_tx("dump");
    check("dump_no_we", we_cnt - base, 0);
    check("dump_busy", int'(busy), 0);

    // Wrap-around, then same low bits with high address bits set
    pay[0] = 8'h11; pay[1] = 8'h22;
    do_load(24'h001FFF, 2);
    wait_idle("wrap");
    check("wrap_ram_1fff", int'(ram[13'h1FFF]), 8'h11);
    check("wrap_ram_0000", int'(ram[0]), 8'h22);
    pay[0] = 8'h33; pay[1] = 8'h44;
    do_load(24'hFF1FFF, 2);
    do_dump(24'h001FFF, 2);
    wait_idle("wrap_hi");
    check("wrap_hi_ram_0000", int'(ram[0]), 8'h44);
    verify_tx("wrap");

    // Unknown command, followed directly by a valid dump
    e0 = err_cnt;
    base = we_cnt;
    hdr(8'h07, 24'h000000, 16'd1);
    exp_tx[exp_n] = 8'h15;
    exp_n++;
    do_dump(24'h000010, 3);
    wait_idle("unknown");
    check("unknown_cmd_err", err_cnt - e0, 1);
    check("unknown_no_we", we_cnt - base, 0);
    verify_tx("unknown");

    // Zero length
    do_load(24'h000400, 0);
    wait_idle("zero_load");
    verify_tx("zero_load");
    do_dump(24'h000400, 0);
    wait_idle("zero_dump");
    verify_tx("zero_dump");

    // Backpressure during a dump
    for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
    do_load(24'h000300, 4);
    wait_idle("bp_load");
    do_dump(24'h000300, 4);
    n = 0;
    while (!transmit && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_first_tx_seen", int'(transmit), 1);
    @(posedge clk);
    #1 hold = 1'b1;
    n0 = tx_n;
    repeat (500) @(negedge clk);
    check("bp_no_tx_while_held", tx_n, n0);
    hold = 1'b0;
    wait_idle("bp");
    verify_tx("bp");

    // Reset after 2 of 4 payload bytes
    base = we_cnt;
    hdr(8'h01, 24'h000200, 16'd4);
    push(8'h5A); push(8'hA5);
    ram_ref[13'h200] = 8'h5A;
    ram_ref[13'h201] = 8'hA5;
    k = 0;
    n = 0;
    while (k < 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (mem_we) k++;
    end
    check("rst_two_writes_seen", k, 2);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_no_more_we", we_cnt - base, 2);
    check_ram("rst", 24'h000200, 2);
    verify_tx("rst");

    // Randomized load/dump pairs
    for (int it = 0; it < 6; it++) begin
      a = 24'($urandom);
      l = $urandom_range(1, 20);
      for (int i = 0; i < l; i++) pay[i] = 8'($urandom);
      do_load(a, l);
      wait_idle("rnd_load");
      check_ram("rnd", a, l);
      off = $urandom_range(0, l - 1);
      dl  = $urandom_range(1, l - off);
      do_dump(a + 24'(off), dl);
      wait_idle("rnd_dump");
      verify_tx("rnd");
    end

    check("protocol_violations", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
